// File: rtl/mac_pkg.sv
// Shared widths and types for the mac16 multiply-accumulate slice.
// Imported by the multiplier and the accumulator top.
package mac_pkg;

    // Default operand width of each unsigned multiplier input.
    localparam int DEF_IN_W  = 16;

    // Default accumulator width; holds a full product at minimum.
    localparam int DEF_ACC_W = 32;

    typedef logic [DEF_IN_W-1:0]  operand_t;
    typedef logic [DEF_ACC_W-1:0] acc_t;

endpackage

// File: rtl/mac16_mult.sv
// Combinational unsigned IN_W x IN_W array multiplier.
// Partial-product rows summed by a balanced binary adder tree.
module mac16_mult
    import mac_pkg::*;
#(
    parameter int IN_W = DEF_IN_W
) (
    input  logic [IN_W-1:0]   a,
    input  logic [IN_W-1:0]   b,
    output logic [2*IN_W-1:0] product
);

    localparam int PW    = 2 * IN_W;
    localparam int NODES = 2 * IN_W - 1;

    // Heap-ordered tree: leaves hold the shifted rows, node 0 the sum.
    logic [PW-1:0] node [NODES];
    logic [PW-1:0] a_ext;

    assign a_ext = {{IN_W{1'b0}}, a};

    // Build the partial-product rows, then fold them pairwise to the root.
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < IN_W; i++) begin
            node[IN_W-1+i] = {PW{b[i]}} & (a_ext << i);
        end
        for (int k = IN_W - 2; k >= 0; k--) begin
            node[k] = node[2*k+1] + node[2*k+2];
        end
    end

    assign product = node[0];

endmodule

// File: rtl/mac16.sv
// Unsigned multiply-accumulate with a registered running sum.
// Adds A*B every cycle; only a synchronous reset clears the sum.
module mac16
    import mac_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    output logic [ACC_W-1:0] accumulator
);

    logic [2*IN_W-1:0] product;
    logic [ACC_W-1:0]  product_ext;
    logic [ACC_W-1:0]  acc_q;

    mac16_mult #(
        .IN_W (IN_W)
    ) u_mult (
        .a       (A),
        .b       (B),
        .product (product)
    );

    // The product is unsigned, so widening is a plain zero-extend.
    assign product_ext = ACC_W'(product);

    // Clear wins over accumulation; the sum wraps at ACC_W bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_q + product_ext;
        end
    end

    assign accumulator = acc_q;

endmodule

// File: tb/tb_mac16.sv
// Directed and random checks of mac16 through an expected-value queue.
// Outputs are sampled 1ns after each rising edge.
module tb_mac16;
    import mac_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    operand_t A;
    operand_t B;
    acc_t     accumulator;

    int   checks   = 0;
    int   failures = 0;
    acc_t sb[$];
    acc_t model;

    mac16 dut (
        .clk         (clk),
        .reset       (reset),
        .A           (A),
        .B           (B),
        .accumulator (accumulator)
    );

    always #5 clk = ~clk;

    // Drive one cycle, queue its expected sum, compare after the edge.
    task automatic step(input string tag, input logic r,
                        input operand_t a, input operand_t b,
                        input acc_t exp);
        acc_t want;
        @(negedge clk);
        reset = r;
        A     = a;
        B     = b;
        sb.push_back(exp);
        model = exp;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            want = sb.pop_front();
            assert (accumulator === want) else begin
                failures++;
                $error("FAIL %s got=%h exp=%h", tag, accumulator, want);
            end
        end
    endtask

    function automatic acc_t next_sum(input acc_t cur, input logic r,
                                      input operand_t a, input operand_t b);
        acc_t p;
        p = acc_t'(a) * acc_t'(b);
        return r ? acc_t'(cur + p) : '0;
    endfunction

    initial begin
        reset = 1'b0;
        A     = '0;
        B     = '0;
        model = '0;

        step("rst0", 1'b0, 0, 0, 32'd0);
        step("rst1", 1'b0, 0, 0, 32'd0);
        step("idle0", 1'b1, 0, 0, 32'd0);
        step("idle1", 1'b1, 0, 0, 32'd0);
        step("2x3", 1'b1, 2, 3, 32'd6);

        step("clr_a", 1'b0, 0, 0, 32'd0);
        step("13x4", 1'b1, 13, 4, 32'd52);
        step("7x3", 1'b1, 7, 3, 32'd73);
        step("3x6", 1'b1, 3, 6, 32'd91);

        step("clr_b", 1'b0, 0, 0, 32'd0);
        step("201x130", 1'b1, 201, 130, 32'd26130);
        step("14x2", 1'b1, 14, 2, 32'd26158);
        step("clr_c", 1'b0, 0, 0, 32'd0);

        step("big", 1'b1, 32091, 11232, 32'd360446112);
        step("2x8", 1'b1, 2, 8, 32'd360446128);

        step("clr_d", 1'b0, 0, 0, 32'd0);
        step("max1", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        step("max2", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFC0002);
        step("max3", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFA0003);

        step("rst_wins", 1'b0, 5, 5, 32'd0);
        step("post_rst", 1'b1, 5, 5, 32'd25);
        step("a_zero", 1'b1, 0, 777, 32'd25);
        step("b_zero", 1'b1, 999, 0, 32'd25);

        for (int i = 0; i < 40; i++) begin
            operand_t ra;
            operand_t rb;
            logic     rr;
            ra = operand_t'($urandom);
            rb = operand_t'($urandom);
            rr = ($urandom_range(0, 9) != 0);
            step("rand", rr, ra, rb, next_sum(model, rr, ra, rb));
        end

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain left=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac16.md
Name: mac16

Overview:
- Unsigned 16x16 multiply-accumulate unit with a 32-bit running accumulator.
- Every clock cycle it adds A*B to the accumulator; there is no enable.
- Used as a leaf arithmetic block in datapaths that need dot-product style accumulation.
- The accumulator is a registered output; the only way to clear it is reset.

Parameters:
- IN_W, 16, width of each unsigned operand A and B.
- ACC_W, 32, accumulator width; must be >= 2*IN_W.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = clear accumulator).
- A  input  IN_W  unsigned multiplicand, sampled every posedge.
- B  input  IN_W  unsigned multiplier, sampled every posedge.
- accumulator  output  ACC_W  registered running sum, driven directly from the state register.

Behaviour:
- Reset: one clock is synchronous and reset is synchronous, active-low.
  - At a posedge with reset==0, accumulator <= 0.
  - A and B are ignored on that edge.
  - No asynchronous path.
- Accumulate: at a posedge with reset==1, accumulator <= accumulator + (A*B).
  - The product is unsigned and zero-extended to ACC_W before the add.
- Latency:
  - A and B applied before edge N appear in accumulator just after edge N (1-cycle registered latency).
  - No combinational path from A or B to accumulator.
- Arithmetic:
  - Product width is 2*IN_W = 32 bits and is exact (max 65535*65535 = 0xFFFE0001).
  - The sum wraps modulo 2^ACC_W; no saturation and no overflow flag.
- Reset mid-operation:
  - The reset edge wins over accumulation.
  - The first edge after reset returns to 1 yields accumulator == A*B of that cycle.
- Zero operands: A==0 or B==0 holds the accumulator unchanged, which is the idle condition.
- Power-up: the value is undefined until the first reset edge; the bench must reset first.

Decomposition:
- Shared package (mac_pkg): IN_W and ACC_W defaults and the typedefs operand_t [IN_W-1:0] and acc_t [ACC_W-1:0].
- One sub-module, mac16_mult:
  - Purely combinational unsigned IN_W x IN_W array/shift-add multiplier producing a 2*IN_W product.
  - Written structurally: partial-product rows plus an adder tree, not the * operator.
- Top level: product zero-extend, adder, accumulator register with synchronous clear.

Test Plan:
- Reset 0 for 2 edges with A=B=0, then reset=1 and A=B=0 for 2 edges -> accumulator == 0 throughout.
- After a clear, A=2, B=3 for 1 edge -> accumulator == 6.
- reset=0 for 1 edge, then reset=1 with:
  - A=13, B=4 -> 52;
  - then A=7, B=3 -> 73;
  - then A=3, B=6 -> 91.
- Reset pulse, then A=201, B=130 -> 26130; then A=14, B=2 -> 26158; then A=B=0 with reset=0 for 1 edge -> 0.
- After a clear:
  - A=32091, B=11232 -> 360446112;
  - then A=2, B=8 -> 360446128.
- Wrap-around: from 0, A=B=65535 for 2 edges -> 0xFFFC0002 (second sum wraps modulo 2^32); a third edge gives 0xFFFA0003.
